voice_allocator: RTL
====================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 5: number of voice slots driven downstream.
REQ-002 SHALL have parameter FIRST_SLOT, default 1: lowest allocatable slot; slots below it SHALL stay off with data 0.
REQ-003 SHALL have parameter HOLDOFF, default 16: idle cycles enforced after each burst pulse.
REQ-004 SHALL have port clk_in  input  1  sole clock; all state changes on posedge.
REQ-005 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port event_valid_in  input  1  note event offered.
REQ-007 SHALL have port event_ready_out  output  1  event accepted when valid&ready at a posedge.
REQ-008 SHALL have port event_on_in  input  1  1=note-on, 0=note-off.
REQ-009 SHALL have port note_in  input  8  MIDI note number.
REQ-010 SHALL have port velocity_in  input  8  MIDI velocity.
REQ-011 SHALL have port panic_in  input  1  single-cycle pulse: release all voices.
REQ-012 SHALL have port on_array_out  output  NUM_VOICES  per-slot active flag.
REQ-013 SHALL have port midi_burst_data_out  output  NUM_VOICES x 16  per slot {note[15:8], velocity[7:0]}.
REQ-014 SHALL have port midi_burst_change_out  output  1  one-cycle pulse: new slot set valid.
REQ-015 SHALL have port busy_out  output  1  high in any state other than IDLE.

Function
REQ-016 States SHALL be IDLE, SCAN, APPLY, ANNOUNCE, HOLD; reset state IDLE.
REQ-017 event_ready_out SHALL equal (state==IDLE) & ~panic_pending & ~rst_in.
REQ-018 On acceptance SHALL capture event_on_in, note_in, velocity_in and enter SCAN; note-on with velocity 0 SHALL be treated as note-off.
REQ-019 SCAN SHALL examine one slot per cycle, FIRST_SLOT upward, for NUM_VOICES-FIRST_SLOT cycles, recording: first slot matching captured note while active, lowest free slot, oldest active slot.
REQ-020 APPLY, note-on, match found: SHALL overwrite that slot's velocity only and reset its age to 0.
REQ-021 APPLY, note-on, no match, free slot: SHALL write {note,velocity}, set on bit, age 0.
REQ-022 APPLY, note-on, no match, no free slot: SHALL steal slot with greatest age (tie -> lowest index), write {note,velocity}, age 0.
REQ-023 Each applied note-on SHALL increment the 8-bit age of every other active slot, saturating at 255.
REQ-024 APPLY, note-off, match found: SHALL clear on bit, data and age of that slot.
REQ-025 APPLY, note-off, no match: SHALL change nothing and return to IDLE with no pulse and no HOLD.
REQ-026 ANNOUNCE SHALL last one cycle with midi_burst_change_out=1; on_array_out and midi_burst_data_out SHALL already hold the new values that cycle.
REQ-027 Latency: burst pulse SHALL be high in the cycle (NUM_VOICES-FIRST_SLOT)+2 cycles after the accepting edge (6 at defaults).
REQ-028 HOLD SHALL last exactly HOLDOFF cycles, then IDLE; HOLDOFF=0 SHALL go ANNOUNCE->IDLE.
REQ-029 on_array_out and midi_burst_data_out SHALL change only in APPLY and be stable otherwise.
REQ-030 panic_in in IDLE SHALL take priority over a simultaneous valid event (event not accepted), clear all slots, go to ANNOUNCE.
REQ-031 panic_in outside IDLE SHALL set panic_pending, serviced on next IDLE cycle; multiple pulses SHALL coalesce.
REQ-032 Panic with all slots already off SHALL still produce one pulse with on_array_out=0.

Reset
REQ-033 While rst_in high: on_array_out=0, all midi_burst_data_out=0, midi_burst_change_out=0, busy_out=0, event_ready_out=0, ages=0, panic_pending=0, HOLD counter=0, state IDLE.
REQ-034 Reset mid-operation SHALL abandon the captured event; no pulse SHALL follow reset release until a new event completes.

Verification
REQ-035 Note-on 60/vel 100 from reset -> pulse 6 cycles after accept; on_array_out=5'b00010, slot1 data=16'h3C64.
REQ-036 Note-ons 60,62,64,65 then 67 -> slot of 60 (oldest) becomes 16'h4350, others unchanged, on_array_out=5'b11110.
REQ-037 Note-on 60 vel 100, then note-on 60 vel 0 -> second pulse with on_array_out=0, slot1 data 0; then note-off 61 -> no pulse, busy_out low after 5 cycles.
REQ-038 Valid held high continuously -> accepts spaced exactly 6+HOLDOFF+1 cycles apart (23 at defaults).
REQ-039 panic_in during HOLD with 3 active voices -> after HOLD, one pulse with on_array_out=0, no pending event lost.
REQ-040 rst_in asserted during SCAN -> outputs zero asynchronously; no pulse after release.

Source files
------------

// File: rtl/voice_allocator.sv
// Voice slot allocator: maps note-on/off events onto NUM_VOICES slots with
// oldest-voice stealing, panic release and a held-off change pulse.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 5,
  parameter int unsigned FIRST_SLOT = 1,
  parameter int unsigned HOLDOFF    = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        event_valid_in,
  output logic                        event_ready_out,
  input  logic                        event_on_in,
  input  logic [7:0]                  note_in,
  input  logic [7:0]                  velocity_in,
  input  logic                        panic_in,
  output logic [NUM_VOICES-1:0]       on_array_out,
  output logic [NUM_VOICES-1:0][15:0] midi_burst_data_out,
  output logic                        midi_burst_change_out,
  output logic                        busy_out
);

  localparam int unsigned IW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned HOLD_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam int unsigned LAST_SLOT = NUM_VOICES - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_APPLY, S_ANNOUNCE, S_HOLD
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic                         r_pend;
  logic                         r_ev_on;
  logic [7:0]                   r_ev_note;
  logic [7:0]                   r_ev_vel;
  logic [IW-1:0]                r_idx;
  logic                         r_match_found;
  logic [IW-1:0]                r_match_idx;
  logic                         r_free_found;
  logic [IW-1:0]                r_free_idx;
  logic                         r_old_found;
  logic [IW-1:0]                r_old_idx;
  logic [7:0]                   r_old_age;
  logic [HW-1:0]                r_hold_cnt;
  logic                         r_change;
  logic [NUM_VOICES-1:0]        r_on;
  logic [NUM_VOICES-1:0][15:0]  r_data;
  logic [7:0]                   r_age [NUM_VOICES];

  logic                         w_ready;
  logic                         w_accept;
  logic                         w_panic_go;
  logic                         w_apply;
  logic [IW-1:0]                w_target;

  assign w_apply  = r_ev_on | r_match_found;
  assign w_target = r_match_found ? r_match_idx :
                    (r_free_found ? r_free_idx : r_old_idx);

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (panic_in || r_pend)  w_next = S_ANNOUNCE;
        else if (event_valid_in) w_next = S_SCAN;
      end
      S_SCAN:     if (r_idx == IW'(LAST_SLOT)) w_next = S_APPLY;
      S_APPLY:    w_next = w_apply ? S_ANNOUNCE : S_IDLE;
      S_ANNOUNCE: w_next = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
      S_HOLD:     if (r_hold_cnt == HW'(HOLD_LAST)) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Handshake and panic decode; panic in IDLE wins over a simultaneous event
  always_comb begin
    w_ready    = 1'b0;
    w_accept   = 1'b0;
    w_panic_go = 1'b0;
    if (r_state == S_IDLE) begin
      w_panic_go = panic_in | r_pend;
      w_ready    = ~r_pend & ~rst_in;
      w_accept   = w_ready & event_valid_in & ~panic_in;
    end
  end

  assign event_ready_out       = w_ready;
  assign busy_out              = (r_state != S_IDLE);
  assign on_array_out          = r_on;
  assign midi_burst_data_out   = r_data;
  assign midi_burst_change_out = r_change;

  // Event capture, slot scan bookkeeping, hold counter and pulse
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pend        <= 1'b0;
      r_ev_on       <= 1'b0;
      r_ev_note     <= '0;
      r_ev_vel      <= '0;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_old_found   <= 1'b0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
      r_hold_cnt    <= '0;
      r_change      <= 1'b0;
    end else begin
      if (r_state != S_IDLE && panic_in) r_pend <= 1'b1;
      else if (r_state == S_IDLE)        r_pend <= 1'b0;

      if (w_accept) begin
        r_ev_on       <= event_on_in & (velocity_in != 8'd0);
        r_ev_note     <= note_in;
        r_ev_vel      <= velocity_in;
        r_idx         <= IW'(FIRST_SLOT);
        r_match_found <= 1'b0;
        r_free_found  <= 1'b0;
        r_old_found   <= 1'b0;
        r_old_age     <= '0;
      end else if (r_state == S_SCAN) begin
        r_idx <= r_idx + IW'(1);
        if (r_on[r_idx] && r_data[r_idx][15:8] == r_ev_note && !r_match_found) begin
          r_match_found <= 1'b1;
          r_match_idx   <= r_idx;
        end
        if (!r_on[r_idx] && !r_free_found) begin
          r_free_found <= 1'b1;
          r_free_idx   <= r_idx;
        end
        // strict '>' keeps the lowest index on equal ages
        if (r_on[r_idx] && (!r_old_found || r_age[r_idx] > r_old_age)) begin
          r_old_found <= 1'b1;
          r_old_idx   <= r_idx;
          r_old_age   <= r_age[r_idx];
        end
      end

      if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + HW'(1);
      else                   r_hold_cnt <= '0;

      r_change <= (w_next == S_ANNOUNCE);
    end
  end

  // Slot image: cleared by panic, otherwise only touched in APPLY
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_on   <= '0;
      r_data <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
    end else if (w_panic_go) begin
      r_on   <= '0;
      r_data <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
    end else if (r_state == S_APPLY) begin
      for (int unsigned i = FIRST_SLOT; i < NUM_VOICES; i++) begin
        if (r_ev_on) begin
          if (IW'(i) == w_target) begin
            r_on[i]   <= 1'b1;
            r_age[i]  <= '0;
            r_data[i] <= r_match_found ? {r_data[i][15:8], r_ev_vel} : {r_ev_note, r_ev_vel};
          end else if (r_on[i] && r_age[i] != 8'hFF) begin
            r_age[i] <= r_age[i] + 8'd1;
          end
        end else if (r_match_found && IW'(i) == r_match_idx) begin
          r_on[i]   <= 1'b0;
          r_data[i] <= '0;
          r_age[i]  <= '0;
        end
      end
    end
  end

endmodule
